// File: rtl/pdata_mac_seq.sv
// Serial-chain MAC processing element: shift-loaded operand/accumulator
// registers, sequential shift-add multiplier and saturating accumulate.
module pdata_mac_seq #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned ACC_W = 64
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] opcode,
    input  logic       signed_mode,
    input  logic       rx,
    output logic       tx,
    output logic       tx_en,
    output logic       done,
    output logic       sat
);

    localparam int unsigned PW    = 2 * SIZE;
    localparam int unsigned CNT_W = (SIZE > 2) ? $clog2(SIZE) : 1;

    localparam logic [2:0] OP_SHIFT_D1  = 3'd0;
    localparam logic [2:0] OP_SHIFT_D2  = 3'd1;
    localparam logic [2:0] OP_SHIFT_ACC = 3'd2;
    localparam logic [2:0] OP_LOAD      = 3'd3;
    localparam logic [2:0] OP_CLR       = 3'd4;
    localparam logic [2:0] OP_MUL       = 3'd5;
    localparam logic [2:0] OP_MUL_ADD   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [SIZE-1:0]    data_1;
    logic [SIZE-1:0]    data_2;
    logic [ACC_W-1:0]   acc;

    logic [PW-1:0]      pp;
    logic [PW-1:0]      mcand;
    logic [SIZE-1:0]    mplier;
    logic [CNT_W-1:0]   cnt;
    logic               m_signed;
    logic               m_add;

    logic               accept;
    logic               is_mul_op;
    logic               last_step;
    logic [PW-1:0]      step_add;
    logic [PW-1:0]      pp_step;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     a_x;
    logic [ACC_W:0]     p_x;
    logic [ACC_W:0]     sum;
    logic               ovf;
    logic [ACC_W-1:0]   clamp_val;

    assign op_ready  = (state == S_IDLE);
    assign accept    = op_valid && (state == S_IDLE);
    assign is_mul_op = (opcode == OP_MUL) || (opcode == OP_MUL_ADD);
    assign last_step = (cnt == CNT_W'(SIZE - 1));

    // Shift-add step; the multiplier MSB carries negative weight in signed mode
    always_comb begin
        step_add = mplier[0] ? mcand : '0;
        pp_step  = (m_signed && last_step) ? (pp - step_add) : (pp + step_add);
    end

    // Product extension and saturating sum at ACC_W+1 bits
    always_comb begin
        prod_ext = m_signed ? {{(ACC_W - PW){pp[PW-1]}}, pp}
                            : {{(ACC_W - PW){1'b0}}, pp};
        a_x      = {m_signed & acc[ACC_W-1], acc};
        p_x      = {m_signed & prod_ext[ACC_W-1], prod_ext};
        sum      = a_x + p_x;
        ovf      = m_signed ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        if (m_signed) begin
            clamp_val = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                   : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            clamp_val = '1;
        end
    end

    // Serial output to the downstream cell for the shift opcodes
    always_comb begin
        tx    = 1'b0;
        tx_en = 1'b0;
        if ((state == S_IDLE) && op_valid) begin
            case (opcode)
                OP_SHIFT_D1: begin
                    tx_en = 1'b1;
                    tx    = data_1[SIZE-1];
                end
                OP_SHIFT_D2: begin
                    tx_en = 1'b1;
                    tx    = data_2[SIZE-1];
                end
                OP_SHIFT_ACC: begin
                    tx_en = 1'b1;
                    tx    = acc[ACC_W-1];
                end
                default: begin
                    tx    = 1'b0;
                    tx_en = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> MULT (SIZE cycles) -> WB -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_mul_op) state_nxt = S_MULT;
            S_MULT:  if (last_step)           state_nxt = S_WB;
            S_WB:                             state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // Datapath: opcode execution, multiplier stepping and writeback
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            data_1   <= '0;
            data_2   <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            done     <= 1'b0;
            pp       <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            m_signed <= 1'b0;
            m_add    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                case (opcode)
                    OP_SHIFT_D1:  data_1 <= {data_1[SIZE-2:0], rx};
                    OP_SHIFT_D2:  data_2 <= {data_2[SIZE-2:0], rx};
                    OP_SHIFT_ACC: acc    <= {acc[ACC_W-2:0], rx};
                    OP_LOAD: begin
                        data_1 <= {data_1[SIZE-2:0], rx};
                        data_2 <= {data_2[SIZE-2:0], data_1[SIZE-1]};
                    end
                    OP_CLR: begin
                        acc <= '0;
                        sat <= 1'b0;
                    end
                    OP_MUL, OP_MUL_ADD: begin
                        mcand    <= signed_mode ? {{(PW - SIZE){data_1[SIZE-1]}}, data_1}
                                                : {{(PW - SIZE){1'b0}}, data_1};
                        mplier   <= data_2;
                        pp       <= '0;
                        cnt      <= '0;
                        m_signed <= signed_mode;
                        m_add    <= (opcode == OP_MUL_ADD);
                    end
                    default: ;
                endcase
            end
            if (state == S_MULT) begin
                pp     <= pp_step;
                mcand  <= {mcand[PW-2:0], 1'b0};
                mplier <= {1'b0, mplier[SIZE-1:1]};
                cnt    <= cnt + CNT_W'(1);
            end
            if (state == S_WB) begin
                done <= 1'b1;
                if (m_add) begin
                    acc <= ovf ? clamp_val : sum[ACC_W-1:0];
                    if (ovf) sat <= 1'b1;
                end else begin
                    acc <= prod_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdata_mac_seq.sv
// Self-checking bench for pdata_mac_seq (SIZE=8, ACC_W=32) against an
// arithmetic reference model of the cell registers.
module tb_pdata_mac_seq;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned ACC_W = 32;

    logic       clk = 1'b0;
    logic       nRst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] opcode;
    logic       signed_mode;
    logic       rx;
    logic       tx;
    logic       tx_en;
    logic       done;
    logic       sat;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_d1;
    logic [7:0]  m_d2;
    logic [31:0] m_acc;
    logic        m_sat;

    pdata_mac_seq #(.SIZE(SIZE), .ACC_W(ACC_W)) dut (
        .clk(clk), .nRst(nRst), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .signed_mode(signed_mode), .rx(rx), .tx(tx),
        .tx_en(tx_en), .done(done), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_d1 = 8'h00; m_d2 = 8'h00; m_acc = 32'h0; m_sat = 1'b0;
    endtask

    // Reference: product and saturated accumulate as plain integer arithmetic
    task automatic model_mul(input logic [2:0] op, input logic sm);
        int     a, b;
        longint p, s, acc_v;
        if (sm) begin
            a = int'($signed(m_d1)); b = int'($signed(m_d2));
        end else begin
            a = int'(m_d1); b = int'(m_d2);
        end
        p = longint'(a) * longint'(b);
        if (op == 3'd5) begin
            m_acc = 32'(p);
        end else if (sm) begin
            acc_v = longint'(int'($signed(m_acc)));
            s = acc_v + p;
            if (s > 64'sd2147483647) begin
                m_acc = 32'h7FFFFFFF; m_sat = 1'b1;
            end else if (s < -64'sd2147483648) begin
                m_acc = 32'h80000000; m_sat = 1'b1;
            end else begin
                m_acc = 32'(s);
            end
        end else begin
            acc_v = longint'({32'h0, m_acc});
            s = acc_v + p;
            if (s > 64'sd4294967295) begin
                m_acc = 32'hFFFFFFFF; m_sat = 1'b1;
            end else begin
                m_acc = 32'(s);
            end
        end
    endtask

    task automatic model_simple(input logic [2:0] op, input logic r);
        logic d1_msb;
        d1_msb = m_d1[7];
        case (op)
            3'd0: m_d1 = {m_d1[6:0], r};
            3'd1: m_d2 = {m_d2[6:0], r};
            3'd2: m_acc = {m_acc[30:0], r};
            3'd3: begin m_d1 = {m_d1[6:0], r}; m_d2 = {m_d2[6:0], d1_msb}; end
            3'd4: begin m_acc = 32'h0; m_sat = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        checks++;
        if (dut.data_1 !== m_d1 || dut.data_2 !== m_d2 || dut.acc !== m_acc || sat !== m_sat) begin
            errors++;
            $display("FAIL regs[%s] got d1=%h d2=%h acc=%h sat=%b want d1=%h d2=%h acc=%h sat=%b",
                     tag, dut.data_1, dut.data_2, dut.acc, sat, m_d1, m_d2, m_acc, m_sat);
        end
    endtask

    // Waits out a multiply after its accept edge; checks busy length and done
    task automatic wait_mul(input logic [2:0] op, input logic sm);
        int low = 0;
        int early_done = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (op_ready) seen = 1;
            else begin
                low++;
                if (done) early_done++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mul_timeout got op_ready=%b want 1 within 40 cycles", op_ready);
        end
        checks++;
        if (low != SIZE + 1) begin
            errors++;
            $display("FAIL busy_len got %0d want %0d", low, SIZE + 1);
        end
        checks++;
        if (done !== 1'b1 || early_done != 0) begin
            errors++;
            $display("FAIL done_pulse got done=%b early=%0d want 1 and 0", done, early_done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width got %b want 0", done);
        end
        model_mul(op, sm);
    endtask

    task automatic issue(input logic [2:0] op, input logic r, input logic sm);
        logic exp_en, exp_tx;
        @(negedge clk);
        op_valid = 1'b1; opcode = op; rx = r; signed_mode = sm;
        #1;
        exp_en = (op <= 3'd2);
        exp_tx = (op == 3'd0) ? m_d1[7] : (op == 3'd1) ? m_d2[7] : (op == 3'd2) ? m_acc[31] : 1'b0;
        checks++;
        if (tx_en !== exp_en || tx !== exp_tx || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx op=%0d got en=%b tx=%b rdy=%b want en=%b tx=%b rdy=1",
                     op, tx_en, tx, op_ready, exp_en, exp_tx);
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
        if (op == 3'd5 || op == 3'd6) wait_mul(op, sm);
        else model_simple(op, r);
    endtask

    task automatic load_pair(input logic [7:0] d1v, input logic [7:0] d2v);
        for (int i = 7; i >= 0; i--) issue(3'd3, d2v[i], 1'b0);
        for (int i = 7; i >= 0; i--) issue(3'd3, d1v[i], 1'b0);
    endtask

    task automatic set_acc(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) issue(3'd2, v[i], 1'b0);
    endtask

    task automatic test_reset();
        nRst = 1'b0; op_valid = 1'b0; opcode = 3'd7; rx = 1'b0; signed_mode = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (op_ready !== 1'b1 || tx_en !== 1'b0 || done !== 1'b0 || sat !== 1'b0 || dut.acc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b en=%b done=%b sat=%b acc=%h want 1 0 0 0 0",
                     op_ready, tx_en, done, sat, dut.acc);
        end
        nRst = 1'b1;
        for (int i = 0; i < 5; i++) issue(3'd2, 1'b1, 1'b0);
        check_regs("pre_reset");
        @(negedge clk); #2 nRst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (op_ready !== 1'b1 || tx_en !== 1'b0 || done !== 1'b0 || sat !== 1'b0 || dut.acc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b en=%b done=%b sat=%b acc=%h want 1 0 0 0 0",
                     op_ready, tx_en, done, sat, dut.acc);
        end
        @(negedge clk); nRst = 1'b1;
    endtask

    task automatic test_shift();
        logic [7:0] pat;
        pat = 8'hA5;
        for (int i = 7; i >= 0; i--) issue(3'd0, pat[i], 1'b0);
        checks++;
        if (dut.data_1 !== 8'hA5) begin
            errors++;
            $display("FAIL shift_in got %h want a5", dut.data_1);
        end
        for (int i = 0; i < 8; i++) issue(3'd0, 1'b0, 1'b0);
        check_regs("shift_out");
        for (int i = 0; i < 8; i++) issue(3'd1, i[0], 1'b0);
        check_regs("shift_d2");
    endtask

    task automatic test_load_mul();
        load_pair(8'h05, 8'h03);
        check_regs("load_chain");
        issue(3'd5, 1'b0, 1'b0);
        checks++;
        if (dut.acc !== 32'h0000000F) begin
            errors++;
            $display("FAIL mul_u_small got %h want 0000000f", dut.acc);
        end
    endtask

    task automatic test_signed_unsigned();
        load_pair(8'hFD, 8'h05);
        issue(3'd5, 1'b0, 1'b1);
        checks++;
        if (dut.acc !== 32'hFFFFFFF1) begin
            errors++;
            $display("FAIL mul_signed got %h want fffffff1", dut.acc);
        end
        issue(3'd5, 1'b0, 1'b0);
        checks++;
        if (dut.acc !== 32'h000004F1) begin
            errors++;
            $display("FAIL mul_unsigned got %h want 000004f1", dut.acc);
        end
        load_pair(8'h80, 8'h80);
        issue(3'd5, 1'b0, 1'b1);
        checks++;
        if (dut.acc !== 32'h00004000) begin
            errors++;
            $display("FAIL mul_minneg got %h want 00004000", dut.acc);
        end
        check_regs("signed_end");
    endtask

    task automatic test_saturation();
        set_acc(32'h7FFFFFF0);
        load_pair(8'h7F, 8'h7F);
        issue(3'd6, 1'b0, 1'b1);
        checks++;
        if (dut.acc !== 32'h7FFFFFFF || sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got acc=%h sat=%b want 7fffffff 1", dut.acc, sat);
        end
        load_pair(8'h00, 8'h00);
        issue(3'd6, 1'b0, 1'b0);
        check_regs("sat_sticky");
        issue(3'd4, 1'b0, 1'b0);
        checks++;
        if (dut.acc !== 32'h0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL clr got acc=%h sat=%b want 0 0", dut.acc, sat);
        end
        set_acc(32'h80000000);
        load_pair(8'h80, 8'h7F);
        issue(3'd6, 1'b0, 1'b1);
        check_regs("sat_neg");
        issue(3'd4, 1'b0, 1'b0);
        set_acc(32'hFFFFFFFF);
        load_pair(8'h01, 8'h01);
        issue(3'd6, 1'b0, 1'b0);
        check_regs("sat_unsigned");
        issue(3'd4, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] op;
        for (int n = 0; n < 250; n++) begin
            op = 3'($urandom_range(0, 7));
            issue(op, 1'($urandom), 1'($urandom));
            if (op >= 3'd4) check_regs("random");
        end
        check_regs("random_end");
    endtask

    task automatic test_back_to_back();
        int low = 0;
        int bad = 0;
        bit seen = 0;
        load_pair(8'($urandom), 8'($urandom));
        @(negedge clk);
        op_valid = 1'b1; opcode = 3'd5; signed_mode = 1'b1; rx = 1'b0;
        @(posedge clk);
        #1 opcode = 3'd0; rx = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (op_ready) seen = 1;
            else begin
                low++;
                if (tx_en !== 1'b0 || done !== 1'b0 || dut.data_1 !== m_d1) bad++;
            end
        end
        checks++;
        if (!seen || low != SIZE + 1 || bad != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL handshake got seen=%0d low=%0d bad=%0d done=%b want 1 %0d 0 1",
                     seen, low, bad, done, SIZE + 1);
        end
        model_mul(3'd5, 1'b1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        model_simple(3'd0, 1'b1);
        check_regs("held_accept_once");
    endtask

    task automatic test_abort();
        int dones = 0;
        load_pair(8'h33, 8'h44);
        @(negedge clk);
        op_valid = 1'b1; opcode = 3'd5; signed_mode = 1'b0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (4) @(negedge clk);
        nRst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut.acc !== 32'h0 || op_ready !== 1'b1 || done !== 1'b0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL abort got acc=%h rdy=%b done=%b sat=%b want 0 1 0 0",
                     dut.acc, op_ready, done, sat);
        end
        @(negedge clk); nRst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_done got %0d pulses want 0", dones);
        end
        check_regs("abort_end");
    endtask

    initial begin
        test_reset();
        test_shift();
        test_load_mul();
        test_signed_unsigned();
        test_saturation();
        test_random();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
